// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus carry flip-flop, LSB first.
// Optional subtraction (a-b) is enabled by defining SERIAL_SUB_EN.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Returns {carry_out, sum} of a single full-adder cell.
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
      full_add = {(x & y) | (y & c) | (c & x), x ^ y ^ c};
   endfunction

   logic [1:0]       state_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-2:0] res_r;
   logic             carry_r;
   logic [CNT_W-1:0] cnt_r;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] s_r;
   logic             co_r;

   logic [1:0]       fa_s;
   logic [WIDTH-1:0] res_cat_s;
   logic [WIDTH-1:0] b_load_s;
   logic             c_load_s;

   // Full-adder stage on the current operand LSBs; res_cat_s is the result after this bit.
   always_comb begin
      fa_s      = full_add(a_r[0], b_r[0], carry_r);
      res_cat_s = {fa_s[0], res_r};
   end

   // Operand B and carry-in values loaded when a new operation is accepted.
`ifdef SERIAL_SUB_EN
   always_comb begin
      if (sub) begin
         b_load_s = ~b;
         c_load_s = 1'b1;
      end else begin
         b_load_s = b;
         c_load_s = cin;
      end
   end
`else
   always_comb begin
      b_load_s = b;
      c_load_s = cin;
   end
`endif

   // Control FSM and serial datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         res_r   <= {(WIDTH-1){1'b0}};
         carry_r <= 1'b0;
         cnt_r   <= CNT_ZERO;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         s_r     <= {WIDTH{1'b0}};
         co_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               done_r <= 1'b0;
               if (start) begin
                  a_r     <= a;
                  b_r     <= b_load_s;
                  carry_r <= c_load_s;
                  cnt_r   <= CNT_ZERO;
                  busy_r  <= 1'b1;
                  state_r <= ST_SHIFT;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               res_r   <= res_cat_s[WIDTH-1:1];
               a_r     <= a_r >> 1;
               b_r     <= b_r >> 1;
               carry_r <= fa_s[1];
               cnt_r   <= cnt_r + CNT_ONE;
               if (cnt_r == CNT_LAST) begin
                  s_r     <= res_cat_s;
                  co_r    <= fa_s[1];
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= ST_DONE;
               end else begin
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
                  state_r <= ST_SHIFT;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign s    = s_r;
   assign co   = co_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8); sub tests need SERIAL_SUB_EN.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         busy;
   logic         done;
   logic [W-1:0] s;
   logic         co;

   int checks;
   int errors;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .s     (s),
      .co    (co)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for done; counts edges and busy cycles, checks s holds old_s meanwhile.
   task automatic wait_done(input string name, input logic [W-1:0] old_s,
                            output int edges, output int busy_cnt);
      edges    = 0;
      busy_cnt = 0;
      while (done !== 1'b1 && edges < 40) begin
         if (busy === 1'b1) busy_cnt++;
         checks++;
         if (s !== old_s) begin
            errors++;
            $display("FAIL %s_hold: s=%h expected %h", name, s, old_s);
         end
         tick();
         edges++;
      end
   endtask

   task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic c, input logic sb, input logic [W-1:0] old_s,
                         input logic [W-1:0] exp_s, input logic exp_co);
      int edges;
      int bcnt;
      a = av; b = bv; cin = c; sub = sb; start = 1'b1;
      tick();
      start = 1'b0;
      a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
      wait_done(name, old_s, edges, bcnt);
      checks++;
      if (edges !== W) begin
         errors++;
         $display("FAIL %s_latency: %0d edges expected %0d", name, edges, W);
      end
      checks++;
      if (bcnt !== W) begin
         errors++;
         $display("FAIL %s_busy: %0d cycles expected %0d", name, bcnt, W);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_busy_done: busy=%b expected 0", name, busy);
      end
      checks++;
      if ({co, s} !== {exp_co, exp_s}) begin
         errors++;
         $display("FAIL %s_result: co=%b s=%h expected co=%b s=%h", name, co, s, exp_co, exp_s);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL %s_pulse: done=%b expected 0", name, done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if ({busy, done, co, s} !== 11'h000) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b co=%b s=%h expected all 0", busy, done, co, s);
      end
   endtask

   task automatic test_add();
      run_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h00, 8'h8D, 1'b0);
      run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h8D, 8'h00, 1'b1);
      run_op("add_cin",   8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0);
      run_op("add_a5_5a", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1);
   endtask

   task automatic test_start_ignored();
      int edges;
      int bcnt;
      int pulses;
      a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
      tick();
      a = 8'hFF; b = 8'hFF; cin = 1'b1;
      wait_done("ignore", 8'h00, edges, bcnt);
      start = 1'b0;
      checks++;
      if (edges !== W) begin
         errors++;
         $display("FAIL ignore_latency: %0d edges expected %0d", edges, W);
      end
      checks++;
      if ({co, s} !== {1'b0, 8'h46}) begin
         errors++;
         $display("FAIL ignore_result: co=%b s=%h expected co=0 s=46", co, s);
      end
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("FAIL ignore_extra: %0d active cycles expected 0", pulses);
      end
   endtask

   task automatic test_rst_mid();
      a = 8'h5A; b = 8'h33; cin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({busy, done, co, s} !== 11'h000) begin
         errors++;
         $display("FAIL rst_mid: busy=%b done=%b co=%b s=%h expected all 0", busy, done, co, s);
      end
      run_op("after_rst", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h00, 8'h10, 1'b0);
   endtask

   task automatic test_back_to_back();
      int edges;
      int bcnt;
      a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("b2b_first", 8'h10, edges, bcnt);
      checks++;
      if ({co, s} !== {1'b1, 8'h00} || edges !== W) begin
         errors++;
         $display("FAIL b2b_first: co=%b s=%h edges=%0d expected co=1 s=00 edges=%0d", co, s, edges, W);
      end
      a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || s !== 8'h00) begin
         errors++;
         $display("FAIL b2b_accept: busy=%b done=%b s=%h expected busy=1 done=0 s=00", busy, done, s);
      end
      wait_done("b2b_second", 8'h00, edges, bcnt);
      checks++;
      if ({co, s} !== {1'b0, 8'h03} || edges !== W || bcnt !== W) begin
         errors++;
         $display("FAIL b2b_second: co=%b s=%h edges=%0d busy=%0d expected co=0 s=03 edges=%0d busy=%0d",
                  co, s, edges, bcnt, W, W);
      end
      tick();
   endtask

`ifdef SERIAL_SUB_EN
   task automatic test_sub();
      run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h03, 8'h0F, 1'b1);
      run_op("sub_00_01", 8'h00, 8'h01, 1'b0, 1'b1, 8'h0F, 8'hFF, 1'b0);
      run_op("sub_cin1",  8'h20, 8'h05, 1'b1, 1'b1, 8'hFF, 8'h1B, 1'b1);
      run_op("sub_off",   8'h20, 8'h05, 1'b1, 1'b0, 8'h1B, 8'h26, 1'b0);
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_add();
      test_start_ignored();
      test_rst_mid();
      test_back_to_back();
`ifdef SERIAL_SUB_EN
      test_sub();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
